// File: rtl/dmem_if.sv
// Data-memory port between the core's M stage and the data-memory responder.
// The core drives address, store data and strobe; the responder returns load data.
interface dmem_if;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        LogOverflow;

    modport master (
        output MemWriteM, ALUOutM, WriteDataM,
        input  ReadDataM, LogOverflow
    );

    modport slave (
        input  MemWriteM, ALUOutM, WriteDataM,
        output ReadDataM, LogOverflow
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, free-running CYCLE counter and an optional
// 4-entry store-log FIFO, enabled by defining DMEM_STORE_LOG_EN.
module dmem_responder #(
   parameter int    DEPTH     = 64,
   parameter string INIT_FILE = ""
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);
   localparam int          AW          = $clog2(DEPTH);
   localparam logic [29:0] CYCLE_W     = 30'h3FFF_C000;
   localparam logic [29:0] LOG_DATA_W  = 30'h3FFF_C001;
   localparam logic [29:0] LOG_STAT_W  = 30'h3FFF_C002;

   logic [31:0]   ram [DEPTH];
   logic [AW-1:0] ram_idx;
   logic [29:0]   word;
   logic          sel_ram;
   logic          sel_cycle;
   logic          we;
   logic [31:0]   cycle;
   logic [31:0]   log_data_rd;
   logic [31:0]   log_status_rd;
   logic          unused_lsbs;

   assign word        = bus.ALUOutM[31:2];
   assign ram_idx     = bus.ALUOutM[AW+1:2];
   assign sel_ram     = (bus.ALUOutM[31:16] == 16'h0000);
   assign sel_cycle   = (word == CYCLE_W);
   assign we          = bus.MemWriteM;
   assign unused_lsbs = ^bus.ALUOutM[1:0];

   // RAM is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (we && sel_ram)
         ram[ram_idx] <= bus.WriteDataM;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cycle <= '0;
      else if (we && sel_cycle)
         cycle <= bus.WriteDataM;
      else
         cycle <= cycle + 32'd1;
   end

`ifdef DMEM_STORE_LOG_EN
   logic [31:0] log_mem [4];
   logic [1:0]  rd_ptr;
   logic [1:0]  wr_ptr;
   logic [2:0]  count;
   logic        overflow;
   logic        log_full;
   logic        log_empty;
   logic        push;
   logic        status_wr;

   assign log_full  = (count == 3'd4);
   assign log_empty = (count == 3'd0);
   assign push      = we && (word == LOG_DATA_W);
   assign status_wr = we && (word == LOG_STAT_W);

   always_ff @(posedge clk) begin
      if (push && !log_full)
         log_mem[wr_ptr] <= bus.WriteDataM;
   end

   // Push and pop target different addresses, so at most one fires per edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (push) begin
         if (log_full) begin
            overflow <= 1'b1;
         end else begin
            wr_ptr <= wr_ptr + 2'd1;
            count  <= count + 3'd1;
         end
      end else if (status_wr) begin
         if (!log_empty) begin
            rd_ptr <= rd_ptr + 2'd1;
            count  <= count - 3'd1;
         end
         if (bus.WriteDataM[16])
            overflow <= 1'b0;
      end
   end

   assign log_data_rd   = log_empty ? 32'h0 : log_mem[rd_ptr];
   assign log_status_rd = {15'h0, overflow, 6'h0, log_empty, log_full, 5'h0, count};
   assign bus.LogOverflow = overflow;
`else
   assign log_data_rd     = 32'h0;
   assign log_status_rd   = 32'h0;
   assign bus.LogOverflow = 1'b0;
`endif

   always_comb begin
      bus.ReadDataM = 32'h0;
      if (sel_ram)
         bus.ReadDataM = ram[ram_idx];
      else if (sel_cycle)
         bus.ReadDataM = cycle;
      else if (word == LOG_DATA_W)
         bus.ReadDataM = log_data_rd;
      else if (word == LOG_STAT_W)
         bus.ReadDataM = log_status_rd;
   end
endmodule
